way_age_tracker: RTL and testbench
==================================

# way_age_tracker

Per-set LRU age tracker that produces the flattened way vector and condition mask consumed by `select_biggest`. It holds one saturating age counter and one valid bit per way, and updates them on cache fill, access, invalidate and flush events. `select_biggest` then returns the largest valid age, i.e. the LRU victim age. The block is the producer (write) side of the `way_flatted`/`condition` interface.

## Interface
- SINGLE_WAY_WIDTH_IN_BITS, 4, width of each way's age counter
- NUM_WAY, 16, number of ways
- WAY_INDEX_WIDTH, 4, width of way index ports; must satisfy 2^WAY_INDEX_WIDTH >= NUM_WAY

- clk_in  input  1  single clock, rising edge
- reset_in  input  1  asynchronous, active-high reset
- access_valid_in  input  1  hit/touch of `access_way_in`
- access_way_in  input  WAY_INDEX_WIDTH  way touched
- fill_valid_in  input  1  line fill into `fill_way_in`
- fill_way_in  input  WAY_INDEX_WIDTH  way filled
- invalidate_valid_in  input  1  invalidate `invalidate_way_in`
- invalidate_way_in  input  WAY_INDEX_WIDTH  way invalidated
- flush_in  input  1  invalidate all ways
- way_flatted_out  output  SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY  ages; way i at bits [i*W +: W]
- condition_out  output  NUM_WAY  per-way valid bit
- valid_count_out  output  WAY_INDEX_WIDTH+1  number of valid ways
- all_valid_out  output  1  high when every way is valid

## Operation
- State: `age[i]` (W bits) and `valid[i]` for each way i. All outputs are driven directly from registers or a registered count. There is no combinational input-to-output path.
- Any index >= NUM_WAY is ignored for that event.
- Effective events per cycle:
  - inv = invalidate_valid_in.
  - fil = fill_valid_in, unless inv is active on the same way. Invalidate wins.
  - acc = access_valid_in && valid[access_way_in], unless the same way is targeted by inv or fil. Access to an invalid way is a no-op.
- flush_in has highest priority. It sets all valid to 0 and all ages to 0, and every other event that cycle is discarded.
- Targeted way updates:
  - inv: valid=0, age=0.
  - fil: valid=1, age=0.
  - acc: age=0, valid unchanged.
- Aging: aging_event = fil || acc. On aging_event, every way that is valid and not targeted this cycle increments its age by exactly 1. Ages saturate at 2^W-1.
  - The increment is at most one per cycle, even when fil and acc hit different ways.
  - Invalid ways hold age 0.
  - inv alone does not age other ways.
- valid_count_out and all_valid_out reflect the registered valid vector from the same cycle.
- Invariant: among valid ways, a way touched more recently never has a larger age than a way touched less recently, except when ties arise from saturation.

## Timing
- Reset (asynchronous assert; deassert synchronous to clk_in): all ages 0, all valid 0, all outputs 0.
- Reset asserted mid-operation clears outputs immediately, without waiting for a clock edge.
- Latency: an event sampled at edge N is visible on the outputs after edge N. There are 1-cycle updates and no stalls.
- Every input is sampled every cycle. There is no handshake and no backpressure.
- Simultaneous events on different ways are all applied in the same cycle, with a single aging step.
- Simultaneous fil and acc on the same way: the way ends at age 0, valid=1, and aging occurs once.

## Test plan
- Reset: hold reset_in, then release. Required: way_flatted_out=0, condition_out=0, valid_count_out=0, all_valid_out=0. Assert reset_in asynchronously between edges mid-test; outputs go to 0 before the next clock edge.
- Fill ways 0,1,2,3 on consecutive cycles. Required: ages way0=3, way1=2, way2=1, way3=0; condition_out=16'h000F; valid_count_out=4.
- Then access way 0. Required: ages way0=0, way1=3, way2=2, way3=1. Then access way 7, which is invalid. Required: no change at all.
- Saturation: fill way 5, then fill way 6 on 20 consecutive cycles. Required: age[5]=4'hF (held, no wrap) and age[6]=0.
- Simultaneous events: with ways 0–3 valid, assert invalidate way 2 and fill way 2 in the same cycle. Required: valid[2]=0, age[2]=0, and no other ages change. Next cycle, fill way 4 and access way 1 together. Required: ways 1 and 4 both at age 0, ways 0 and 3 each incremented by exactly 1, valid_count_out=4.
- Fill all 16 ways, then assert flush_in together with access_valid_in. Required: all_valid_out=1 before the flush. After the flush: all outputs 0. Also feed the outputs to `select_biggest` after the 16-way fill sequence 0..15. Required: select_out=4'hF, the age of way 0.

Source files
------------

// File: rtl/way_age_tracker.sv
// Per-set LRU age tracker: one saturating age counter and one valid bit per way.
// Drives the way_flatted/condition inputs of select_biggest, with all outputs registered.
module way_age_tracker #(
  parameter int unsigned SINGLE_WAY_WIDTH_IN_BITS = 4,
  parameter int unsigned NUM_WAY                  = 16,
  parameter int unsigned WAY_INDEX_WIDTH          = 4
) (
  input  logic                                         clk_in,
  input  logic                                         reset_in,
  input  logic                                         access_valid_in,
  input  logic [WAY_INDEX_WIDTH-1:0]                   access_way_in,
  input  logic                                         fill_valid_in,
  input  logic [WAY_INDEX_WIDTH-1:0]                   fill_way_in,
  input  logic                                         invalidate_valid_in,
  input  logic [WAY_INDEX_WIDTH-1:0]                   invalidate_way_in,
  input  logic                                         flush_in,
  output logic [SINGLE_WAY_WIDTH_IN_BITS*NUM_WAY-1:0]  way_flatted_out,
  output logic [NUM_WAY-1:0]                           condition_out,
  output logic [WAY_INDEX_WIDTH:0]                     valid_count_out,
  output logic                                         all_valid_out
);

  localparam int unsigned W  = SINGLE_WAY_WIDTH_IN_BITS;
  localparam int unsigned N  = NUM_WAY;
  localparam int unsigned IW = WAY_INDEX_WIDTH;
  localparam int unsigned CW = WAY_INDEX_WIDTH + 1;
  localparam logic [W-1:0] AGE_MAX = {W{1'b1}};

  logic [N-1:0]   inv_sel;
  logic [N-1:0]   fil_req;
  logic [N-1:0]   fil_sel;
  logic [N-1:0]   acc_req;
  logic [N-1:0]   acc_sel;
  logic           aging;
  logic [W*N-1:0] ages_nxt;
  logic [N-1:0]   valid_nxt;
  logic [CW-1:0]  count_nxt;

  // One-hot event decode; out-of-range indices match no way and are dropped.
  always_comb begin : decode
    inv_sel = '0;
    fil_req = '0;
    acc_req = '0;
    for (int i = 0; i < int'(N); i++) begin
      inv_sel[i] = invalidate_valid_in && (invalidate_way_in == IW'(i));
      fil_req[i] = fill_valid_in && (fill_way_in == IW'(i));
      acc_req[i] = access_valid_in && (access_way_in == IW'(i)) && condition_out[i];
    end
    // Invalidate beats fill; access yields to either on the same way.
    fil_sel = fil_req & ~inv_sel;
    acc_sel = acc_req & ~inv_sel & ~fil_req;
    aging   = (|fil_sel) || (|acc_sel);
  end

  // Per-way next state, with a single aging step shared by fill and access.
  always_comb begin : next_state
    ages_nxt  = way_flatted_out;
    valid_nxt = condition_out;
    count_nxt = '0;
    for (int i = 0; i < int'(N); i++) begin
      if (flush_in) begin
        ages_nxt[i*W +: W] = '0;
        valid_nxt[i]       = 1'b0;
      end else if (inv_sel[i]) begin
        ages_nxt[i*W +: W] = '0;
        valid_nxt[i]       = 1'b0;
      end else if (fil_sel[i]) begin
        ages_nxt[i*W +: W] = '0;
        valid_nxt[i]       = 1'b1;
      end else if (acc_sel[i]) begin
        ages_nxt[i*W +: W] = '0;
      end else if (aging && condition_out[i] && (way_flatted_out[i*W +: W] != AGE_MAX)) begin
        ages_nxt[i*W +: W] = way_flatted_out[i*W +: W] + W'(1);
      end
      count_nxt = count_nxt + CW'(valid_nxt[i]);
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      way_flatted_out <= '0;
      condition_out   <= '0;
      valid_count_out <= '0;
      all_valid_out   <= 1'b0;
    end else begin
      way_flatted_out <= ages_nxt;
      condition_out   <= valid_nxt;
      valid_count_out <= count_nxt;
      all_valid_out   <= &valid_nxt;
    end
  end

endmodule

// File: tb/tb_way_age_tracker.sv
// Scoreboarded random/directed bench for way_age_tracker against an event-level age model.
module tb_way_age_tracker;

  localparam int AW = 4;
  localparam int NW = 16;
  localparam int IW = 4;
  localparam int MAXAGE = 15;

  logic                 clk;
  logic                 rst;
  logic                 acc_v;
  logic [IW-1:0]        acc_w;
  logic                 fil_v;
  logic [IW-1:0]        fil_w;
  logic                 inv_v;
  logic [IW-1:0]        inv_w;
  logic                 flush;
  logic [AW*NW-1:0]     ages;
  logic [NW-1:0]        cond;
  logic [IW:0]          cnt;
  logic                 all_v;

  typedef struct {
    logic [AW*NW-1:0] ages;
    logic [NW-1:0]    cond;
    int               cnt;
    bit               all_v;
    int               max_age;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;

  int   m_age[NW];
  bit   m_valid[NW];

  way_age_tracker #(
    .SINGLE_WAY_WIDTH_IN_BITS(AW),
    .NUM_WAY(NW),
    .WAY_INDEX_WIDTH(IW)
  ) dut (
    .clk_in(clk),
    .reset_in(rst),
    .access_valid_in(acc_v),
    .access_way_in(acc_w),
    .fill_valid_in(fil_v),
    .fill_way_in(fil_w),
    .invalidate_valid_in(inv_v),
    .invalidate_way_in(inv_w),
    .flush_in(flush),
    .way_flatted_out(ages),
    .condition_out(cond),
    .valid_count_out(cnt),
    .all_valid_out(all_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
    end
  endtask

  // Largest age among valid ways, i.e. what select_biggest returns.
  function automatic int max_valid_age(input logic [AW*NW-1:0] a, input logic [NW-1:0] v);
    int m;
    logic [AW*NW-1:0] t;
    m = 0;
    t = a;
    for (int i = 0; i < NW; i++)
      if (v[i] && int'(t[i*AW +: AW]) > m) m = int'(t[i*AW +: AW]);
    return m;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NW; i++) begin
      m_age[i]   = 0;
      m_valid[i] = 1'b0;
    end
  endtask

  // Reference: apply one cycle of events by the event rules, on plain integers.
  task automatic model_step(input bit av, input int aw, input bit fv, input int fw,
                            input bit iv, input int iw, input bit fl);
    bit fil_ok, acc_ok, touched;
    if (fl) begin
      model_clear();
      return;
    end
    fil_ok = fv && !(iv && iw == fw);
    acc_ok = av && m_valid[aw] && !(iv && iw == aw) && !(fv && fw == aw);
    if (fil_ok || acc_ok)
      for (int i = 0; i < NW; i++) begin
        touched = (iv && iw == i) || (fil_ok && fw == i) || (acc_ok && aw == i);
        if (!touched && m_valid[i]) m_age[i] = (m_age[i] + 1 > MAXAGE) ? MAXAGE : m_age[i] + 1;
      end
    if (acc_ok) m_age[aw] = 0;
    if (fil_ok) begin
      m_valid[fw] = 1'b1;
      m_age[fw]   = 0;
    end
    if (iv) begin
      m_valid[iw] = 1'b0;
      m_age[iw]   = 0;
    end
  endtask

  function automatic exp_t model_snapshot();
    exp_t e;
    e.ages = '0;
    e.cond = '0;
    e.cnt  = 0;
    e.max_age = 0;
    for (int i = 0; i < NW; i++) begin
      e.ages[i*AW +: AW] = AW'(m_age[i]);
      e.cond[i] = m_valid[i];
      if (m_valid[i]) begin
        e.cnt++;
        if (m_age[i] > e.max_age) e.max_age = m_age[i];
      end
    end
    e.all_v = (e.cnt == NW);
    return e;
  endfunction

  task automatic step(input bit av, input int aw, input bit fv, input int fw,
                      input bit iv, input int iw, input bit fl);
    @(negedge clk);
    acc_v = av; acc_w = IW'(aw);
    fil_v = fv; fil_w = IW'(fw);
    inv_v = iv; inv_w = IW'(iw);
    flush = fl;
    model_step(av, aw, fv, fw, iv, iw, fl);
    exp_q.push_back(model_snapshot());
  endtask

  task automatic fill(input int w);
    step(1'b0, 0, 1'b1, w, 1'b0, 0, 1'b0);
  endtask

  // Go idle and wait, bounded, until the monitor has consumed every expectation.
  task automatic drain();
    bit done;
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    done = 1'b0;
    for (int k = 0; k < 6 && !done; k++) begin
      @(posedge clk);
      #2;
      if (exp_q.size() == 0) done = 1'b1;
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ages"}, 64'(ages), 64'd0);
    chk({tag, "_cond"}, 64'(cond), 64'd0);
    chk({tag, "_cnt"}, 64'(cnt), 64'd0);
    chk({tag, "_all"}, 64'(all_v), 64'd0);
  endtask

  // Monitor: every cycle's outputs are compared against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("sb_ages", 64'(ages), 64'(e.ages));
        chk("sb_cond", 64'(cond), 64'(e.cond));
        chk("sb_cnt", 64'(cnt), 64'(e.cnt));
        chk("sb_all", 64'(all_v), 64'(e.all_v));
        chk("sb_max_age", 64'(max_valid_age(ages, cond)), 64'(e.max_age));
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    acc_v = 1'b0; acc_w = '0;
    fil_v = 1'b0; fil_w = '0;
    inv_v = 1'b0; inv_w = '0;
    flush = 1'b0;
    model_clear();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // Fill ways 0..3 on consecutive cycles.
    for (int w = 0; w < 4; w++) fill(w);
    drain();
    chk("fill4_ages", 64'(ages[15:0]), 64'h0123);
    chk("fill4_cond", 64'(cond), 64'h000F);
    chk("fill4_cnt", 64'(cnt), 64'd4);

    step(1'b1, 0, 1'b0, 0, 1'b0, 0, 1'b0);
    drain();
    chk("acc0_ages", 64'(ages[15:0]), 64'h1230);
    step(1'b1, 7, 1'b0, 0, 1'b0, 0, 1'b0);
    drain();
    chk("acc7_ages", 64'(ages), 64'h1230);
    chk("acc7_cond", 64'(cond), 64'h000F);

    // Saturation: way 5 ages past the counter limit while way 6 is refilled.
    fill(5);
    for (int k = 0; k < 20; k++) fill(6);
    drain();
    chk("sat_age5", 64'(ages[23:20]), 64'hF);
    chk("sat_age6", 64'(ages[27:24]), 64'h0);

    // Simultaneous events from a clean set with ways 0..3 valid.
    step(1'b0, 0, 1'b0, 0, 1'b0, 0, 1'b1);
    for (int w = 0; w < 4; w++) fill(w);
    step(1'b0, 0, 1'b1, 2, 1'b1, 2, 1'b0);
    drain();
    chk("invfil_cond2", 64'(cond[2]), 64'd0);
    chk("invfil_ages", 64'(ages[15:0]), 64'h0023);
    step(1'b1, 1, 1'b1, 4, 1'b0, 0, 1'b0);
    drain();
    chk("filacc_ages", 64'(ages[19:0]), 64'h01004);
    chk("filacc_cnt", 64'(cnt), 64'd4);

    // Fill all ways in order; way 0 becomes the oldest and select_biggest yields 4'hF.
    for (int w = 0; w < NW; w++) fill(w);
    drain();
    chk("full_all", 64'(all_v), 64'd1);
    chk("full_cnt", 64'(cnt), 64'd16);
    chk("full_select", 64'(max_valid_age(ages, cond)), 64'hF);
    chk("full_age0", 64'(ages[3:0]), 64'hF);
    step(1'b1, 3, 1'b0, 0, 1'b0, 0, 1'b1);
    drain();
    chk_zero("flush");

    // Random traffic, including colliding ways and occasional flushes.
    for (int k = 0; k < 400; k++) begin
      step(($urandom_range(0, 1) == 1), int'($urandom_range(0, NW - 1)),
           ($urandom_range(0, 2) != 0), int'($urandom_range(0, NW - 1)),
           ($urandom_range(0, 4) == 0), int'($urandom_range(0, NW - 1)),
           ($urandom_range(0, 59) == 0));
    end
    drain();

    // Asynchronous reset between clock edges.
    for (int w = 0; w < 4; w++) fill(w);
    drain();
    chk("pre_areset_cnt_nonzero", 64'(cnt != 0), 64'd1);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk_zero("async_reset");
    model_clear();
    @(negedge clk);
    rst = 1'b0;
    fill(9);
    drain();
    chk("post_reset_cond", 64'(cond), 64'h0200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
